// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded control and operands, bypasses the
// same-cycle WB write, pre-computes EX forwarding selects and detects load-use hazards.
module id_ex_stage #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_in,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [4:0]         id_dest,
    input  logic [DATA_W-1:0]  id_read_data1,
    input  logic [DATA_W-1:0]  id_read_data2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_alu_src,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               exmem_reg_write,
    input  logic [4:0]         exmem_dest,
    input  logic               wb_reg_write_en,
    input  logic [4:0]         wb_dest,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [4:0]         ex_dest,
    output logic [DATA_W-1:0]  ex_op_a,
    output logic [DATA_W-1:0]  ex_op_b,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [1:0]         ex_fwd_a,
    output logic [1:0]         ex_fwd_b,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   bubble_count
);

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // $0 is hardwired to zero, so it never forwards and never creates a hazard.
    function automatic logic src_match(input logic uses, input logic [4:0] r,
                                       input logic [4:0] src);
        return uses && (r != 5'd0) && (r == src);
    endfunction

    logic              rs_from_ex, rt_from_ex;
    logic              rs_from_mem, rt_from_mem;
    logic              rs_from_wb, rt_from_wb;
    logic              load_use;
    logic              insert_bubble;
    logic [1:0]        fwd_a_nxt, fwd_b_nxt;
    logic [DATA_W-1:0] op_a_nxt, op_b_nxt;

    always_comb begin
        rs_from_ex  = ex_valid && ex_reg_write && src_match(id_uses_rs, ex_dest, id_rs);
        rt_from_ex  = ex_valid && ex_reg_write && src_match(id_uses_rt, ex_dest, id_rt);
        rs_from_mem = exmem_reg_write && src_match(id_uses_rs, exmem_dest, id_rs);
        rt_from_mem = exmem_reg_write && src_match(id_uses_rt, exmem_dest, id_rt);
        rs_from_wb  = wb_reg_write_en && src_match(id_uses_rs, wb_dest, id_rs);
        rt_from_wb  = wb_reg_write_en && src_match(id_uses_rt, wb_dest, id_rt);

        // The instruction now in EX has priority over the older one in EX/MEM.
        if (rs_from_ex)
            fwd_a_nxt = FWD_EXMEM;
        else if (rs_from_mem)
            fwd_a_nxt = FWD_MEMWB;
        else
            fwd_a_nxt = FWD_REG;

        if (rt_from_ex)
            fwd_b_nxt = FWD_EXMEM;
        else if (rt_from_mem)
            fwd_b_nxt = FWD_MEMWB;
        else
            fwd_b_nxt = FWD_REG;

        // register_file is not write-through, so its read port is stale on a WB hit.
        op_a_nxt = rs_from_wb ? wb_data : id_read_data1;
        op_b_nxt = rt_from_wb ? wb_data : id_read_data2;
    end

    assign load_use = ex_valid && ex_mem_read &&
                      (src_match(id_uses_rs, ex_dest, id_rs) ||
                       src_match(id_uses_rt, ex_dest, id_rt));

    assign hazard_stall  = id_valid && load_use && !flush;
    assign insert_bubble = flush || hazard_stall || !id_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_alu_src   <= 1'b0;
            ex_alu_op    <= '0;
            ex_dest      <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_imm       <= '0;
            ex_fwd_a     <= FWD_REG;
            ex_fwd_b     <= FWD_REG;
            bubble_count <= '0;
        end else if (!stall_in) begin
            if (insert_bubble) begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_alu_src   <= 1'b0;
                ex_alu_op    <= '0;
                ex_dest      <= '0;
                ex_op_a      <= '0;
                ex_op_b      <= '0;
                ex_imm       <= '0;
                ex_fwd_a     <= FWD_REG;
                ex_fwd_b     <= FWD_REG;
                // Only squashed real instructions count; idle ID slots do not.
                if (id_valid && (bubble_count != {CNT_W{1'b1}}))
                    bubble_count <= bubble_count + CNT_W'(1);
            end else begin
                ex_valid     <= 1'b1;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
                ex_mem_write <= id_mem_write;
                ex_alu_src   <= id_alu_src;
                ex_alu_op    <= id_alu_op;
                ex_dest      <= id_dest;
                ex_op_a      <= op_a_nxt;
                ex_op_b      <= op_b_nxt;
                ex_imm       <= id_imm;
                ex_fwd_a     <= fwd_a_nxt;
                ex_fwd_b     <= fwd_b_nxt;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model checked every cycle plus directed literal checks.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in, flush, id_valid;
    logic [4:0]  id_rs, id_rt, id_dest, exmem_dest, wb_dest;
    logic        id_uses_rs, id_uses_rt;
    logic [31:0] id_read_data1, id_read_data2, id_imm, wb_data;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic [3:0]  id_alu_op;
    logic        exmem_reg_write, wb_reg_write_en;

    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_dest;
    logic [31:0] ex_op_a, ex_op_b, ex_imm;
    logic [1:0]  ex_fwd_a, ex_fwd_b;
    logic        hazard_stall;
    logic [15:0] bubble_count;

    logic        s_valid, s_rw, s_mr, s_mw, s_as, s_haz;
    logic [3:0]  s_op;
    logic [4:0]  s_dest;
    logic [31:0] s_a, s_b, s_imm;
    logic [1:0]  s_fa, s_fb;
    logic [3:0]  bubble_count4;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
        .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest),
        .wb_reg_write_en(wb_reg_write_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_dest(ex_dest), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b), .hazard_stall(hazard_stall),
        .bubble_count(bubble_count)
    );

    // Narrow counter instance to reach saturation quickly.
    id_ex_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .stall_in(stall_in), .flush(flush), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_read_data1(id_read_data1), .id_read_data2(id_read_data2),
        .id_imm(id_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
        .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest),
        .wb_reg_write_en(wb_reg_write_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .ex_valid(s_valid), .ex_reg_write(s_rw), .ex_mem_read(s_mr),
        .ex_mem_write(s_mw), .ex_alu_src(s_as), .ex_alu_op(s_op),
        .ex_dest(s_dest), .ex_op_a(s_a), .ex_op_b(s_b), .ex_imm(s_imm),
        .ex_fwd_a(s_fa), .ex_fwd_b(s_fb), .hazard_stall(s_haz),
        .bubble_count(bubble_count4)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v, rw, mr, mw, as;
        logic [3:0]  op;
        logic [4:0]  dest;
        logic [31:0] a, b, imm;
        logic [1:0]  fa, fb;
    } ex_t;

    ex_t m;
    int  m_cnt;

    function automatic logic reads(input logic uses, input logic [4:0] src, input logic [4:0] r);
        return uses && r != 0 && r == src;
    endfunction

    function automatic logic m_haz();
        return id_valid && !flush && m.v && m.mr &&
               (reads(id_uses_rs, id_rs, m.dest) || reads(id_uses_rt, id_rt, m.dest));
    endfunction

    function automatic logic [1:0] m_sel(input logic uses, input logic [4:0] src);
        if (m.v && m.rw && reads(uses, src, m.dest)) return 2'd1;
        if (exmem_reg_write && reads(uses, src, exmem_dest)) return 2'd2;
        return 2'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        ex_t nx;
        if (!reset) begin
            m     <= '0;
            m_cnt <= 0;
        end else if (!stall_in) begin
            nx = '0;
            if (flush || m_haz() || !id_valid) begin
                if (id_valid) m_cnt <= m_cnt + 1;
            end else begin
                nx.v    = 1'b1;
                nx.rw   = id_reg_write;
                nx.mr   = id_mem_read;
                nx.mw   = id_mem_write;
                nx.as   = id_alu_src;
                nx.op   = id_alu_op;
                nx.dest = id_dest;
                nx.imm  = id_imm;
                nx.a    = (wb_reg_write_en && reads(id_uses_rs, id_rs, wb_dest)) ? wb_data : id_read_data1;
                nx.b    = (wb_reg_write_en && reads(id_uses_rt, id_rt, wb_dest)) ? wb_data : id_read_data2;
                nx.fa   = m_sel(id_uses_rs, id_rs);
                nx.fb   = m_sel(id_uses_rt, id_rt);
            end
            m <= nx;
        end
    end

    always @(negedge clk) begin
        chk("ex_valid", ex_valid, m.v);
        chk("ex_reg_write", ex_reg_write, m.rw);
        chk("ex_mem_read", ex_mem_read, m.mr);
        chk("ex_mem_write", ex_mem_write, m.mw);
        chk("ex_alu_src", ex_alu_src, m.as);
        chk("ex_alu_op", ex_alu_op, m.op);
        chk("ex_dest", ex_dest, m.dest);
        chk("ex_op_a", ex_op_a, m.a);
        chk("ex_op_b", ex_op_b, m.b);
        chk("ex_imm", ex_imm, m.imm);
        chk("ex_fwd_a", ex_fwd_a, m.fa);
        chk("ex_fwd_b", ex_fwd_b, m.fb);
        chk("hazard_stall", hazard_stall, m_haz());
        chk("bubble_count", bubble_count, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("bubble_count4", bubble_count4, (m_cnt > 15) ? 15 : m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                          input logic urt, input logic [4:0] dest, input logic [31:0] d1,
                          input logic [31:0] d2, input logic rw, input logic mr);
        id_valid      = 1'b1;
        id_rs         = rs;
        id_rt         = rt;
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        id_dest       = dest;
        id_read_data1 = d1;
        id_read_data2 = d2;
        id_reg_write  = rw;
        id_mem_read   = mr;
    endtask

    initial begin
        reset = 1'b0;
        stall_in = 0; flush = 0;
        id_imm = 32'h0000_00A5; id_mem_write = 1; id_alu_src = 1; id_alu_op = 4'h9;
        exmem_reg_write = 1; exmem_dest = 5'd5;
        wb_reg_write_en = 1; wb_dest = 5'd5; wb_data = 32'hDEAD;
        set_id(5'd5, 5'd8, 1, 1, 5'd3, 32'd7, 32'd9, 1, 1);
        tick(); tick();
        chk("rst ex_valid", ex_valid, 0);
        chk("rst ex_op_a", ex_op_a, 0);
        chk("rst bubble_count", bubble_count, 0);

        // Plain load of operands
        exmem_reg_write = 0; wb_reg_write_en = 0; id_mem_write = 0; id_alu_src = 0;
        id_alu_op = 4'h2;
        set_id(5'd5, 5'd8, 1, 1, 5'd5, 32'd25, 32'd58, 1, 0);
        #3 reset = 1'b1;
        tick();
        chk("basic op_a", ex_op_a, 25);
        chk("basic op_b", ex_op_b, 58);
        chk("basic fwd_a", ex_fwd_a, 0);
        chk("basic fwd_b", ex_fwd_b, 0);
        chk("basic imm", ex_imm, 32'hA5);

        // EX dest=5 matches rs -> 01
        set_id(5'd5, 5'd8, 1, 1, 5'd6, 32'd1, 32'd2, 1, 0);
        tick();
        chk("fwd ex", ex_fwd_a, 2'b01);
        // EX/MEM dest=5 -> 10
        exmem_reg_write = 1; exmem_dest = 5'd5;
        set_id(5'd5, 5'd8, 1, 1, 5'd7, 32'd1, 32'd2, 1, 0);
        tick();
        chk("fwd exmem", ex_fwd_a, 2'b10);
        // Both match -> 01
        exmem_dest = 5'd7;
        set_id(5'd7, 5'd8, 1, 1, 5'd10, 32'd1, 32'd2, 1, 0);
        tick();
        chk("fwd both", ex_fwd_a, 2'b01);

        // WB bypass of stale rt
        exmem_reg_write = 0;
        wb_reg_write_en = 1; wb_dest = 5'd8; wb_data = 32'd99;
        set_id(5'd1, 5'd8, 1, 1, 5'd11, 32'd4, 32'd58, 1, 0);
        tick();
        chk("wb op_b", ex_op_b, 99);
        chk("wb fwd_b", ex_fwd_b, 0);
        wb_reg_write_en = 0;

        // Load-use hazard
        set_id(5'd2, 5'd0, 1, 0, 5'd8, 32'd3, 32'd0, 1, 1);
        tick();
        set_id(5'd3, 5'd8, 1, 1, 5'd12, 32'd6, 32'd7, 1, 0);
        #1 chk("lu hazard", hazard_stall, 1);
        tick();
        chk("lu bubble", ex_valid, 0);
        chk("lu count", bubble_count, 1);
        chk("lu cleared", hazard_stall, 0);
        exmem_reg_write = 1; exmem_dest = 5'd8;
        tick();
        chk("lu fwd_b", ex_fwd_b, 2'b10);
        chk("lu valid", ex_valid, 1);
        exmem_reg_write = 0;

        // $0 load never stalls
        set_id(5'd2, 5'd0, 1, 0, 5'd0, 32'd3, 32'd0, 1, 1);
        tick();
        set_id(5'd3, 5'd0, 1, 1, 5'd12, 32'd6, 32'd7, 1, 0);
        #1 chk("zero nostall", hazard_stall, 0);
        tick();

        // Flush
        flush = 1;
        tick();
        chk("flush valid", ex_valid, 0);
        chk("flush count", bubble_count, 2);
        flush = 0;

        // Flush + hazard
        set_id(5'd2, 5'd0, 1, 0, 5'd9, 32'd3, 32'd0, 1, 1);
        tick();
        set_id(5'd9, 5'd0, 1, 0, 5'd13, 32'd6, 32'd7, 1, 0);
        flush = 1;
        #1 chk("flush+haz stall", hazard_stall, 0);
        tick();
        chk("flush+haz count", bubble_count, 3);
        flush = 0;

        // stall_in holds everything
        set_id(5'd1, 5'd2, 1, 1, 5'd14, 32'h1234, 32'h5678, 1, 0);
        tick();
        stall_in = 1; flush = 1;
        set_id(5'd3, 5'd4, 1, 1, 5'd15, 32'hAAAA, 32'hBBBB, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall op_a", ex_op_a, 32'h1234);
            chk("stall dest", ex_dest, 14);
        end
        stall_in = 0; flush = 0;

        // Reset mid-stall
        set_id(5'd2, 5'd0, 1, 0, 5'd4, 32'd3, 32'd0, 1, 1);
        tick();
        set_id(5'd4, 5'd0, 1, 0, 5'd13, 32'd6, 32'd7, 1, 0);
        #1 chk("pre-rst hazard", hazard_stall, 1);
        #1 reset = 0;
        #1 chk("mid-rst hazard", hazard_stall, 0);
        chk("mid-rst valid", ex_valid, 0);
        #1 reset = 1;

        // Saturation
        flush = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("sat count4", bubble_count4, 15);
        chk("sat count16", bubble_count, 20);
        flush = 0;
        id_valid = 0;
        tick();
        chk("idle nocount", bubble_count, 20);
        chk("idle bubble", ex_valid, 0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
